// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq -- sequential 32-bit multiply/divide unit with HI/LO registers.
//
// One operation takes 34 clock edges from the accepted start to the HI/LO
// update: PREP (1 edge) turns the operands into magnitudes, RUN (32 edges)
// does one bit per edge (shift-add multiply or restoring divide), and FIX
// (1 edge) applies the result signs and writes HI/LO.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   launch request, only looked at in IDLE
//   op_div  in   0 = multiply, 1 = divide
//   sgn     in   1 = signed operands, 0 = unsigned
//   a       in   multiplicand / dividend / mthi-mtlo write data
//   b       in   multiplier / divisor
//   mthi    in   write a into HI (IDLE only)
//   mtlo    in   write a into LO (IDLE only)
//   busy    out  high whenever an operation is in flight
//   done    out  one-cycle pulse after HI/LO are written by an operation
//   hi, lo  out  HI and LO registers
//   div0    out  last operation was a divide by zero
// ---------------------------------------------------------------------------
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;        // captured a, then |a| (multiplicand)
    logic [WIDTH-1:0] b_q, b_d;        // captured b, then |b| (divisor)
    logic             op_div_q, op_div_d;
    logic             sgn_q, sgn_d;
    logic             neg_res_q, neg_res_d;   // product / quotient negative
    logic             neg_rem_q, neg_rem_d;   // remainder negative
    logic [WIDTH-1:0] acc_q, acc_d;    // product high half / partial remainder
    logic [WIDTH-1:0] mq_q, mq_d;      // multiplier / dividend-quotient
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div0_q, div0_d;

    // Datapath helpers
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               b_zero;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;

    assign abs_a  = (sgn_q && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
    assign abs_b  = (sgn_q && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;
    assign b_zero = (b_q == '0);

    // Multiply step: add multiplicand when the current multiplier bit is set,
    // then shift the whole {acc, mq} pair right by one.
    assign mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});

    // Divide step: shift the next dividend bit into the remainder and try
    // subtracting the divisor; keep the difference only if it did not go negative.
    assign div_shift = {acc_q, mq_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, b_q});

    assign prod = {acc_q, mq_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_div_d  = op_div_q;
        sgn_d     = sgn_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        div0_d    = div0_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // A start wins over a simultaneous move: the move is dropped.
                    state_d  = PREP;
                    a_d      = a;
                    b_d      = b;
                    op_div_d = op_div;
                    sgn_d    = sgn;
                    div0_d   = 1'b0;
                end else begin
                    if (mthi) hi_d = a;
                    if (mtlo) lo_d = a;
                end
            end
            PREP: begin
                state_d   = RUN;
                cnt_d     = 5'd0;
                neg_res_d = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_rem_d = sgn_q & a_q[WIDTH-1];
                // Divide by zero returns the raw dividend in HI, so keep it as is.
                a_d       = (op_div_q && b_zero) ? a_q : abs_a;
                b_d       = abs_b;
                acc_d     = '0;
                mq_d      = op_div_q ? abs_a : abs_b;
            end
            RUN: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX;
                if (op_div_q) begin
                    acc_d = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], div_ge};
                end else begin
                    {acc_d, mq_d} = {mul_sum, mq_q[WIDTH-1:1]};
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!op_div_q) begin
                    {hi_d, lo_d} = neg_res_q ? (~prod + 1'b1) : prod;
                end else if (b_zero) begin
                    lo_d   = '1;
                    hi_d   = a_q;
                    div0_d = 1'b1;
                end else begin
                    lo_d = neg_res_q ? (~mq_q + 1'b1) : mq_q;
                    hi_d = neg_rem_q ? (~acc_q + 1'b1) : acc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            a_q       <= '0;
            b_q       <= '0;
            op_div_q  <= 1'b0;
            sgn_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            mq_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_div_q  <= op_div_d;
            sgn_q     <= sgn_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            div0_q    <= div0_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign div0 = div0_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq -- directed self-checking bench for muldiv_seq.
// Each task drives one scenario and compares against hand-computed values.
// Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_div;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;

    int checks;
    int failures;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_div (op_div),
        .sgn    (sgn),
        .a      (a),
        .b      (b),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo),
        .div0   (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch an operation (caller is at a falling edge) and wait for done.
    // lat = number of rising edges after the accepting edge until done is seen
    // (-1 on timeout). hold_ok = busy stayed high and hi/lo stayed unchanged
    // until done.
    task automatic run_op(input logic div_i, input logic sgn_i,
                          input logic [31:0] a_i, input logic [31:0] b_i,
                          output int lat, output logic hold_ok);
        logic [31:0] hi0, lo0;
        hi0     = hi;
        lo0     = lo;
        lat     = -1;
        hold_ok = 1'b1;
        op_div  = div_i;
        sgn     = sgn_i;
        a       = a_i;
        b       = b_i;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        // Scramble inputs: the captured copies must be used.
        a       = 32'hDEAD_BEEF;
        b       = 32'h0000_0003;
        op_div  = ~div_i;
        sgn     = ~sgn_i;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) begin
                @(posedge clk);
                @(negedge clk);
            end
            if (done) begin
                lat = k;
                break;
            end
            if (!busy || hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
            if (k == 1) begin
                // first sample is right after E0; keep stepping
            end
        end
    endtask

    // Variant used above loops from k=1 sampling right after E0; advance one
    // more edge per iteration so that lat counts edges after E0.
    task automatic go(input logic div_i, input logic sgn_i,
                      input logic [31:0] a_i, input logic [31:0] b_i,
                      output int lat, output logic hold_ok);
        logic [31:0] hi0, lo0;
        hi0     = hi;
        lo0     = lo;
        lat     = -1;
        hold_ok = 1'b1;
        op_div  = div_i;
        sgn     = sgn_i;
        a       = a_i;
        b       = b_i;
        start   = 1'b1;
        @(posedge clk);          // E0
        @(negedge clk);
        start   = 1'b0;
        a       = 32'hDEAD_BEEF;
        b       = 32'h0000_0003;
        op_div  = ~div_i;
        sgn     = ~sgn_i;
        if (!busy) hold_ok = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (!busy || hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; op_div = 1'b0; sgn = 1'b0;
        a = '0; b = '0; mthi = 1'b0; mtlo = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div0 !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b div0=%b hi=%h lo=%h required 0/0/0/0/0",
                     busy, done, div0, hi, lo);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: busy=%b hi=%h lo=%h", busy, hi, lo);
    endtask

    task automatic test_mul_unsigned();
        int lat; logic hold_ok;
        go(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h2, lat, hold_ok);
        checks++;
        if (lat !== 34 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mul_u_latency: lat=%0d busy=%b required lat=34 busy=0", lat, busy);
        end
        checks++;
        if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE || div0 !== 1'b0) begin
            failures++;
            $display("FAIL mul_u_result: hi=%h lo=%h div0=%b required 00000001 fffffffe 0", hi, lo, div0);
        end
        checks++;
        if (hold_ok !== 1'b1) begin
            failures++;
            $display("FAIL mul_u_hold: hold_ok=%b required 1", hold_ok);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL mul_u_done_pulse: done=%b required 0 one cycle later", done);
        end
        $display("mul unsigned ffffffff*2: lat=%0d hi=%h lo=%h", lat, hi, lo);
    endtask

    task automatic test_mul_signed();
        int lat; logic hold_ok;
        go(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, lat, hold_ok);
        checks++;
        if (lat !== 34 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1 || div0 !== 1'b0) begin
            failures++;
            $display("FAIL mul_s: lat=%0d hi=%h lo=%h div0=%b required 34 ffffffff fffffff1 0",
                     lat, hi, lo, div0);
        end
        $display("mul signed -3*5: hi=%h lo=%h", hi, lo);
        go(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, lat, hold_ok);
        checks++;
        if (hi !== 32'h4000_0000 || lo !== 32'h0) begin
            failures++;
            $display("FAIL mul_s_min: hi=%h lo=%h required 40000000 00000000", hi, lo);
        end
        $display("mul signed min*min: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_div_signed();
        int lat; logic hold_ok;
        go(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, hold_ok);
        checks++;
        if (lat !== 34 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || div0 !== 1'b0) begin
            failures++;
            $display("FAIL div_s: lat=%0d lo=%h hi=%h div0=%b required 34 fffffffd ffffffff 0",
                     lat, lo, hi, div0);
        end
        $display("div signed -7/2: lo=%h hi=%h", lo, hi);
        go(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, hold_ok);
        checks++;
        if (lo !== 32'h8000_0000 || hi !== 32'h0 || div0 !== 1'b0) begin
            failures++;
            $display("FAIL div_s_ovf: lo=%h hi=%h div0=%b required 80000000 00000000 0", lo, hi, div0);
        end
        $display("div signed min/-1: lo=%h hi=%h", lo, hi);
        go(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, lat, hold_ok);
        checks++;
        if (lo !== 32'hFFFF_FFFD || hi !== 32'h1) begin
            failures++;
            $display("FAIL div_s_negdivisor: lo=%h hi=%h required fffffffd 00000001", lo, hi);
        end
        $display("div signed 7/-2: lo=%h hi=%h", lo, hi);
    endtask

    task automatic test_div_zero();
        int lat; logic hold_ok;
        go(1'b1, 1'b0, 32'd10, 32'd0, lat, hold_ok);
        checks++;
        if (lat !== 34 || lo !== 32'hFFFF_FFFF || hi !== 32'hA || div0 !== 1'b1) begin
            failures++;
            $display("FAIL div0_u: lat=%0d lo=%h hi=%h div0=%b required 34 ffffffff 0000000a 1",
                     lat, lo, hi, div0);
        end
        $display("div unsigned 10/0: lo=%h hi=%h div0=%b", lo, hi, div0);
        // Next accepted start clears the flag right away.
        op_div = 1'b0; sgn = 1'b0; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (div0 !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL div0_clear: div0=%b busy=%b required 0 1", div0, busy);
        end
        for (int k = 0; k < 40 && !done; k++) @(negedge clk);
        checks++;
        if (lo !== 32'd12 || hi !== 32'h0 || div0 !== 1'b0) begin
            failures++;
            $display("FAIL div0_then_mul: lo=%h hi=%h div0=%b required 0000000c 0 0", lo, hi, div0);
        end
        $display("mul after div0 3*4: lo=%h div0=%b", lo, div0);
        go(1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, lat, hold_ok);
        checks++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFFB || div0 !== 1'b1) begin
            failures++;
            $display("FAIL div0_s: lo=%h hi=%h div0=%b required ffffffff fffffffb 1", lo, hi, div0);
        end
        $display("div signed -5/0: lo=%h hi=%h div0=%b", lo, hi, div0);
    endtask

    task automatic test_busy_ignore();
        int lat;
        logic [31:0] hi0;
        hi0 = hi;
        lat = -1;
        op_div = 1'b0; sgn = 1'b0; a = 32'd6; b = 32'd9; start = 1'b1;
        @(posedge clk);          // E0
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) begin
                start = 1'b1; mthi = 1'b1; a = 32'h55; op_div = 1'b1;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (k == 10 && hi !== hi0) begin
                checks++;
                failures++;
                $display("FAIL busy_mthi: hi=%h required %h", hi, hi0);
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0; mthi = 1'b0;
        checks++;
        if (lat !== 34 || lo !== 32'd54 || hi !== 32'h0) begin
            failures++;
            $display("FAIL busy_ignore: lat=%0d hi=%h lo=%h required 34 00000000 00000036", lat, hi, lo);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_no_queue: busy=%b required 0", busy);
        end
        $display("busy ignore 6*9: lat=%0d lo=%h", lat, lo);
    endtask

    task automatic test_moves();
        logic saw_done;
        saw_done = 1'b0;
        a = 32'h1234; mtlo = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mtlo = 1'b0;
        saw_done = done;
        checks++;
        if (lo !== 32'h0000_1234 || saw_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mtlo: lo=%h done=%b busy=%b required 00001234 0 0", lo, saw_done, busy);
        end
        $display("mtlo 1234: lo=%h", lo);
        a = 32'hCAFE_F00D; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        checks++;
        if (hi !== 32'hCAFE_F00D || lo !== 32'hCAFE_F00D || done !== 1'b0) begin
            failures++;
            $display("FAIL mthi_mtlo: hi=%h lo=%h done=%b required cafef00d cafef00d 0", hi, lo, done);
        end
        $display("mthi+mtlo: hi=%h lo=%h", hi, lo);
        // start together with a move: move is dropped, hi/lo hold.
        op_div = 1'b0; sgn = 1'b0; a = 32'd2; b = 32'd3; start = 1'b1; mthi = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        checks++;
        if (hi !== 32'hCAFE_F00D || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_with_move: hi=%h busy=%b required cafef00d 1", hi, busy);
        end
        for (int k = 0; k < 40 && !done; k++) @(negedge clk);
        checks++;
        if (lo !== 32'd6 || hi !== 32'h0) begin
            failures++;
            $display("FAIL start_with_move_result: hi=%h lo=%h required 0 00000006", hi, lo);
        end
        $display("start+mthi 2*3: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_reset_midop();
        logic saw_done;
        int lat; logic hold_ok;
        saw_done = 1'b0;
        a = 32'hABCD; mthi = 1'b1;
        @(negedge clk);
        mthi = 1'b0;
        op_div = 1'b1; sgn = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);          // E0
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_midop: busy=%b hi=%h lo=%h done=%b required 0 0 0 0", busy, hi, lo, done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || hi !== 32'h0 || lo !== 32'h0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_midop_nodone: spurious done or hi/lo change seen=%b required 0", saw_done);
        end
        $display("reset mid-op: busy=%b hi=%h lo=%h", busy, hi, lo);
        // Reset release followed by an immediate start.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        go(1'b1, 1'b0, 32'd100, 32'd7, lat, hold_ok);
        checks++;
        if (lat !== 34 || lo !== 32'd14 || hi !== 32'd2 || hold_ok !== 1'b1) begin
            failures++;
            $display("FAIL after_reset_op: lat=%0d lo=%h hi=%h hold=%b required 34 0000000e 00000002 1",
                     lat, lo, hi, hold_ok);
        end
        $display("after reset 100/7: lo=%h hi=%h", lo, hi);
    endtask

    task automatic test_back_to_back();
        int lat; logic hold_ok;
        go(1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, lat, hold_ok);
        // done cycle: state already IDLE, so a start here is accepted.
        go(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0001_0000, lat, hold_ok);
        checks++;
        if (lat !== 34 || lo !== 32'h0000_FFFF || hi !== 32'h0000_FFFF) begin
            failures++;
            $display("FAIL back_to_back: lat=%0d lo=%h hi=%h required 34 0000ffff 0000ffff", lat, lo, hi);
        end
        $display("back-to-back ffffffff/10000: lo=%h hi=%h", lo, hi);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_mul_unsigned();
        test_mul_signed();
        test_div_signed();
        test_div_zero();
        test_busy_ignore();
        test_moves();
        test_reset_midop();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
